// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a registered-read or first-word-fall-through output,
// occupancy flags, and sticky overflow/underflow error flags.
module param_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 2,
  parameter int unsigned FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic                         read_enable,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         clear_errors,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_ok, rd_ok;

  assign count        = count_q;
  assign full         = (count_q == FULL_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_ok   = write_enable && !full;
    rd_ok   = read_enable && !empty;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_ok) tail_d = tail_q + AW'(1);
    if (rd_ok) head_d = head_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new error event in the same cycle as clear_errors keeps the flag set.
    overflow_d  = (clear_errors ? 1'b0 : overflow_q)  | (write_enable && full);
    underflow_d = (clear_errors ? 1'b0 : underflow_q) | (read_enable && empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem_q[tail_q] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out   = mem_q[head_q];
    assign data_valid = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;

    always_comb begin
      dout_d   = rd_ok ? mem_q[head_q] : dout_q;
      dvalid_d = rd_ok;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        dvalid_q <= dvalid_d;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
  end

endmodule
